hci_hwpe_wide_interconnect: RTL and testbench
=============================================

Name: hci_hwpe_wide_interconnect

Overview:
- Parametrised successor of the HWPE wide-port interconnect.
- Splits one wide HWPE port (DWH bits = NB_IN_CHAN words of WWH bits) across NB_OUT_CHAN word-interleaved TCDM banks, with any word alignment and row wrap-around.
- Differs from the previous generation in three ways:
  - banks may grant independently over several cycles; each granted bank is retired and only the remaining banks keep requesting;
  - responses are collected per lane and merged;
  - word width is generic, not fixed at 32 bits.
- Sits between an HWPE streamer port and the TCDM bank ports of the cluster.

Parameters:
- NB_OUT_CHAN, 8, number of banks; power of 2, ≥ NB_IN_CHAN.
- DWH, 128, wide port data width; multiple of WWH.
- WWH, 32, bank word width; power of 2, ≥ 8.
- AWH, 32, address width.
- AWM, 12, row (word-within-bank) address width.
- NB_IN_CHAN, DWH/WWH, derived lane count.
- BOFF, $clog2(WWH/8), derived byte-offset bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- clear_i  in  1  synchronous clear of all internal state.
- in_req_i  in  1  wide request.
- in_gnt_o  out  1  wide grant.
- in_wen_i  in  1  1 = read, 0 = write.
- in_add_i  in  AWH  byte address.
- in_be_i  in  DWH/8  byte enables.
- in_data_i  in  DWH  write data.
- in_r_data_o  out  DWH  read data.
- in_r_valid_o  out  1  response valid.
- out_req_o  out  NB_OUT_CHAN  per-bank request.
- out_gnt_i  in  NB_OUT_CHAN  per-bank grant.
- out_wen_o  out  NB_OUT_CHAN  per-bank wen.
- out_add_o  out  NB_OUT_CHAN*AWH  per-bank address = {zeros, row, BOFF zeros}.
- out_be_o  out  NB_OUT_CHAN*WWH/8  per-bank byte enables.
- out_data_o  out  NB_OUT_CHAN*WWH  per-bank write data.
- out_r_data_i  in  NB_OUT_CHAN*WWH  per-bank read data; valid exactly 1 cycle after that bank's req&gnt.

Behaviour:
- Address decode:
  - off = add[BOFF+log2(NB_OUT_CHAN)-1:BOFF].
  - row = add[BOFF+log2(NB_OUT_CHAN)+AWM-1 : BOFF+log2(NB_OUT_CHAN)].
- Lane mapping: lane i goes to bank b = (off+i) mod NB_OUT_CHAN. Its row is row+1 (mod 2^AWM) when off+i ≥ NB_OUT_CHAN, otherwise row. Banks with no lane: req/be/data/add/wen = 0.
- Grant tracking: register gmask[NB_IN_CHAN], reset 0.
  - out_req for lane i = in_req_i & ~gmask[i].
  - lane_done[i] = gmask[i] | out_gnt[b].
  - in_gnt_o = in_req_i & (&lane_done), combinational.
  - On in_gnt_o: gmask <= 0. Otherwise gmask <= gmask | granted lanes.
- Request stability: in_req_i/add/wen/be/data must stay stable until in_gnt_o. Violation is undefined behaviour; the bench asserts it.
- Response path:
  - Per-lane capture register rdat[i] and capture mask cmask.
  - bank_rv[b] = registered out_req[b] & out_gnt[b], reset 0.
  - Live lane valid: lv[i] = bank_rv[b(i)], where b uses the offset latched at that lane's grant (latched offset register).
  - cmask accumulates lv.
  - in_r_valid_o = rpend & &(cmask | lv). rpend is set on in_gnt_o.
  - in_r_data_o lane i = lv[i] ? live bank data : rdat[i].
  - On in_r_valid_o: cmask cleared; rpend cleared unless a new in_gnt_o occurs in the same cycle.
  - Writes produce in_r_valid_o too; r_data is don't-care.
- Latency:
  - All banks grant at once: in_gnt_o same cycle, in_r_valid_o next cycle.
  - In general: in_r_valid_o exactly 1 cycle after in_gnt_o.
  - Throughput: 1 wide request/cycle.
- Reset values: gmask, cmask, rpend, bank_rv = 0; in_gnt_o=0 (in_req_i=0); in_r_valid_o=0; all out_req_o=0.
- clear_i: same effect as reset, synchronously. A pending response is dropped with no in_r_valid_o. Reset or clear mid-transaction leaves no stale grants.
- Simultaneous events: last-lane grant of request N and first lanes of request N+1 cannot overlap, because gmask clears on in_gnt_o. A response for N and grants for N+1 in the same cycle are legal.

Optional Feature:
- Macro HCI_WIDE_IC_STALL_CNT_EN adds output stall_cnt_o [15:0].
  - Counts cycles with in_req_i & ~in_gnt_o; saturates at 0xFFFF.
  - Reset/clear_i set it to 0.
- Without the macro: port and counter absent, no other behaviour change.

Test Plan:
- Aligned read: add=0x40, all gnt=1 → lanes on banks 0–3 at row 2 (out_add 0x8); in_gnt_o same cycle; in_r_valid_o next cycle with in_r_data_o = {bank3, bank2, bank1, bank0} data.
- Wrap: add=0x18 → banks 6,7 at row 0 and banks 0,1 at row 1 (out_add 0x4); lane order in in_r_data_o = {b1, b0, b7, b6}.
- Partial grant: add=0x0, bank 2 gnt held low 3 cycles → banks 0,1,3 req drop after their grant; in_gnt_o in cycle 4; in_r_valid_o in cycle 5 with all four words correct.
- Back-to-back writes to 0x0 then 0x10, all grants high → in_gnt_o on 2 consecutive cycles; in_r_valid_o on the following 2 cycles; bank be/data match lanes.
- Row wrap: add with row=0xFFF, off=6 → lanes 2,3 use row 0x000.
- rst_i pulsed while bank 2 is stalled → all outputs 0; no in_r_valid_o after release; the next request completes normally. With HCI_WIDE_IC_STALL_CNT_EN, stall_cnt_o = 3 after the partial-grant scenario.

Source files
------------

// File: rtl/hci_hwpe_wide_interconnect.sv
// rtl/hci_hwpe_wide_interconnect.sv - wide HWPE port split across word-interleaved TCDM banks
//
// Purpose:
//   Maps one wide request (NB_IN_CHAN words of WWH bits) onto NB_OUT_CHAN
//   word-interleaved banks. The request may start at any word alignment and
//   may wrap past the last bank into the next row. Banks may grant over
//   several cycles. A lane that has been granted stops requesting. The
//   per-lane read responses are gathered into one wide response.
//
// Ports:
//   clk_i, rst_i (async, active high), clear_i (sync clear of all state)
//   in_req_i/in_gnt_o/in_wen_i/in_add_i/in_be_i/in_data_i  wide request side
//   in_r_data_o/in_r_valid_o                               wide response side
//   out_req_o/out_gnt_i/out_wen_o/out_add_o/out_be_o/out_data_o  per-bank request
//   out_r_data_i                                           per-bank read data, 1 cycle after req&gnt
//   stall_cnt_o  saturating count of stalled request cycles (HCI_WIDE_IC_STALL_CNT_EN only)
//
// Optional feature macro: HCI_WIDE_IC_STALL_CNT_EN
module hci_hwpe_wide_interconnect #(
  parameter int unsigned NB_OUT_CHAN = 8,
  parameter int unsigned DWH         = 128,
  parameter int unsigned WWH         = 32,
  parameter int unsigned AWH         = 32,
  parameter int unsigned AWM         = 12,
  parameter int unsigned NB_IN_CHAN  = DWH / WWH,
  parameter int unsigned BOFF        = $clog2(WWH / 8)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         in_req_i,
  output logic                         in_gnt_o,
  input  logic                         in_wen_i,
  input  logic [AWH-1:0]               in_add_i,
  input  logic [DWH/8-1:0]             in_be_i,
  input  logic [DWH-1:0]               in_data_i,
  output logic [DWH-1:0]               in_r_data_o,
  output logic                         in_r_valid_o,
  output logic [NB_OUT_CHAN-1:0]       out_req_o,
  input  logic [NB_OUT_CHAN-1:0]       out_gnt_i,
  output logic [NB_OUT_CHAN-1:0]       out_wen_o,
  output logic [NB_OUT_CHAN*AWH-1:0]   out_add_o,
  output logic [NB_OUT_CHAN*WWH/8-1:0] out_be_o,
  output logic [NB_OUT_CHAN*WWH-1:0]   out_data_o,
  input  logic [NB_OUT_CHAN*WWH-1:0]   out_r_data_i
`ifdef HCI_WIDE_IC_STALL_CNT_EN
  ,
  output logic [15:0]                  stall_cnt_o
`endif
);

  localparam int unsigned LOG_NB = $clog2(NB_OUT_CHAN);
  localparam int unsigned PW     = LOG_NB + 1;
  localparam int unsigned BEW    = WWH / 8;

  logic [LOG_NB-1:0]     off;
  logic [AWM-1:0]        row;
  logic [NB_IN_CHAN-1:0] gmask_q, cmask_q, lane_rv_q;
  logic [NB_IN_CHAN-1:0] lane_req, lane_gnt, lane_done;
  logic                  rpend_q;

  logic [LOG_NB-1:0] lane_bank   [NB_IN_CHAN];
  logic [LOG_NB-1:0] lane_bank_q [NB_IN_CHAN];
  logic [AWM-1:0]    lane_row    [NB_IN_CHAN];
  logic [WWH-1:0]    lane_rdata  [NB_IN_CHAN];
  logic [WWH-1:0]    rdat_q      [NB_IN_CHAN];

  logic [NB_OUT_CHAN-1:0] bank_req, bank_wen;
  logic [AWH-1:0]         bank_add   [NB_OUT_CHAN];
  logic [BEW-1:0]         bank_be    [NB_OUT_CHAN];
  logic [WWH-1:0]         bank_data  [NB_OUT_CHAN];
  logic [WWH-1:0]         bank_rdata [NB_OUT_CHAN];

  assign off = in_add_i[BOFF +: LOG_NB];
  assign row = in_add_i[BOFF+LOG_NB +: AWM];

  for (genvar i = 0; i < NB_IN_CHAN; i++) begin : g_lane
    // pos carries one extra bit: its MSB set means the lane wrapped into the next row
    logic [PW-1:0] pos;
    assign pos           = {1'b0, off} + PW'(i);
    assign lane_bank[i]  = pos[LOG_NB-1:0];
    assign lane_row[i]   = row + AWM'(pos[LOG_NB]);
    assign lane_req[i]   = in_req_i & ~gmask_q[i];
    assign lane_gnt[i]   = lane_req[i] & out_gnt_i[lane_bank[i]];
    assign lane_done[i]  = gmask_q[i] | out_gnt_i[lane_bank[i]];
    assign lane_rdata[i] = bank_rdata[lane_bank_q[i]];
    // a lane's word is forwarded live in its response cycle, otherwise taken from capture
    assign in_r_data_o[i*WWH +: WWH] = lane_rv_q[i] ? lane_rdata[i] : rdat_q[i];
  end

  assign in_gnt_o = in_req_i & (&lane_done);

  // each bank receives at most one lane because NB_OUT_CHAN >= NB_IN_CHAN
  always_comb begin
    bank_req = '0;
    bank_wen = '0;
    for (int b = 0; b < NB_OUT_CHAN; b++) begin
      bank_add[b]  = '0;
      bank_be[b]   = '0;
      bank_data[b] = '0;
    end
    for (int i = 0; i < NB_IN_CHAN; i++) begin
      bank_req[lane_bank[i]]  = lane_req[i];
      bank_wen[lane_bank[i]]  = in_wen_i;
      bank_add[lane_bank[i]]  = AWH'(lane_row[i]) << BOFF;
      bank_be[lane_bank[i]]   = in_be_i[i*BEW +: BEW];
      bank_data[lane_bank[i]] = in_data_i[i*WWH +: WWH];
    end
  end

  assign out_req_o = bank_req;
  assign out_wen_o = bank_wen;

  for (genvar b = 0; b < NB_OUT_CHAN; b++) begin : g_bank
    assign out_add_o[b*AWH +: AWH]  = bank_add[b];
    assign out_be_o[b*BEW +: BEW]   = bank_be[b];
    assign out_data_o[b*WWH +: WWH] = bank_data[b];
    assign bank_rdata[b]            = out_r_data_i[b*WWH +: WWH];
  end

  // Response valid is tracked per lane (not per bank) so that a bank reused by
  // the next request under a different offset cannot be mistaken for a lane
  // of the current one.
  assign in_r_valid_o = rpend_q & (&(cmask_q | lane_rv_q));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gmask_q   <= '0;
      cmask_q   <= '0;
      lane_rv_q <= '0;
      rpend_q   <= 1'b0;
      for (int i = 0; i < NB_IN_CHAN; i++) begin
        lane_bank_q[i] <= '0;
        rdat_q[i]      <= '0;
      end
    end else if (clear_i) begin
      gmask_q   <= '0;
      cmask_q   <= '0;
      lane_rv_q <= '0;
      rpend_q   <= 1'b0;
      for (int i = 0; i < NB_IN_CHAN; i++) begin
        lane_bank_q[i] <= '0;
        rdat_q[i]      <= '0;
      end
    end else begin
      gmask_q   <= in_gnt_o ? '0 : (gmask_q | lane_gnt);
      lane_rv_q <= lane_gnt;
      cmask_q   <= in_r_valid_o ? '0 : (cmask_q | lane_rv_q);
      if (in_gnt_o)
        rpend_q <= 1'b1;
      else if (in_r_valid_o)
        rpend_q <= 1'b0;
      for (int i = 0; i < NB_IN_CHAN; i++) begin
        if (lane_gnt[i])
          lane_bank_q[i] <= lane_bank[i];
        if (lane_rv_q[i])
          rdat_q[i] <= lane_rdata[i];
      end
    end
  end

`ifdef HCI_WIDE_IC_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (clear_i)
      stall_cnt_o <= '0;
    else if (in_req_i && !in_gnt_o && (stall_cnt_o != 16'hFFFF))
      stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hci_hwpe_wide_interconnect.sv
// tb/tb_hci_hwpe_wide_interconnect.sv - self-checking bench for hci_hwpe_wide_interconnect
module tb_hci_hwpe_wide_interconnect;

  localparam int NB = 8;
  localparam int NL = 4;

  logic           clk_i = 1'b0;
  logic           rst_i, clear_i;
  logic           in_req_i, in_gnt_o, in_wen_i;
  logic [31:0]    in_add_i;
  logic [15:0]    in_be_i;
  logic [127:0]   in_data_i, in_r_data_o;
  logic           in_r_valid_o;
  logic [NB-1:0]  out_req_o, out_gnt_i, out_wen_o;
  logic [255:0]   out_add_o;
  logic [31:0]    out_be_o;
  logic [255:0]   out_data_o;
  logic [255:0]   out_r_data_i;
`ifdef HCI_WIDE_IC_STALL_CNT_EN
  logic [15:0]    stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hci_hwpe_wide_interconnect dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .in_req_i     (in_req_i),
    .in_gnt_o     (in_gnt_o),
    .in_wen_i     (in_wen_i),
    .in_add_i     (in_add_i),
    .in_be_i      (in_be_i),
    .in_data_i    (in_data_i),
    .in_r_data_o  (in_r_data_o),
    .in_r_valid_o (in_r_valid_o),
    .out_req_o    (out_req_o),
    .out_gnt_i    (out_gnt_i),
    .out_wen_o    (out_wen_o),
    .out_add_o    (out_add_o),
    .out_be_o     (out_be_o),
    .out_data_o   (out_data_o),
    .out_r_data_i (out_r_data_i)
`ifdef HCI_WIDE_IC_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // bank read word: {bank, row, cycle of grant}; the cycle field exposes stale captures
  function automatic logic [31:0] word(input int b, input int r, input int c);
    logic [31:0] w;
    w = {8'(b), 12'(r), 12'(c)};
    return w;
  endfunction

  // shared between the monitor (writer, negedge) and the bank responder (reader, posedge)
  int            cyc = 0;
  logic [NB-1:0] hit = '0;
  logic [31:0]   pw [NB];

  // ---------------------------------------------------------------- model + compare
  initial begin : mon
    int            off, row, newdue;
    int            lb [NL];
    int            lr [NL];
    logic          all, due, due_read, prev_stall, prev_wen;
    logic [NL-1:0] done;
    logic [127:0]  due_data, prev_data;
    logic [31:0]   lane_exp [NL];
    logic [31:0]   prev_add, e_be;
    logic [15:0]   prev_be;
    logic [NB-1:0] e_req, e_wen;
    logic [255:0]  e_add, e_data;
    done = '0; due = 1'b0; due_read = 1'b0; due_data = '0; prev_stall = 1'b0;
    prev_wen = 1'b0; prev_add = '0; prev_be = '0; prev_data = '0;
    for (int i = 0; i < NL; i++) lane_exp[i] = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        done = '0;
        due  = 1'b0;
      end
      off = int'(in_add_i[4:2]);
      row = int'(in_add_i[16:5]);
      e_req = '0; e_wen = '0; e_add = '0; e_be = '0; e_data = '0;
      all = in_req_i;
      for (int i = 0; i < NL; i++) begin
        lb[i] = (off + i) % NB;
        lr[i] = (row + (((off + i) >= NB) ? 1 : 0)) % 4096;
        e_req[lb[i]]          = in_req_i && !done[i];
        e_wen[lb[i]]          = in_wen_i;
        e_add[lb[i]*32 +: 32] = 32'(lr[i] * 4);
        e_be[lb[i]*4 +: 4]    = in_be_i[i*4 +: 4];
        e_data[lb[i]*32 +: 32] = in_data_i[i*32 +: 32];
        if (!(done[i] || out_gnt_i[lb[i]])) all = 1'b0;
      end
      chk("out_req", out_req_o, e_req);
      chk("out_wen", out_wen_o, e_wen);
      chk("out_add", out_add_o, e_add);
      chk("out_be", out_be_o, e_be);
      chk("out_data", out_data_o, e_data);
      chk("in_gnt", in_gnt_o, all);
      chk("r_valid", in_r_valid_o, due);
      if (due && due_read) chk("r_data", in_r_data_o, due_data);

      if (prev_stall && !rst_i && !clear_i)
        assert (in_req_i && in_wen_i == prev_wen && in_add_i == prev_add &&
                in_be_i == prev_be && in_data_i == prev_data)
          else $error("request changed before grant");
      prev_stall = in_req_i && !in_gnt_o;
      prev_wen = in_wen_i; prev_add = in_add_i; prev_be = in_be_i; prev_data = in_data_i;

      if (rst_i || clear_i) begin
        done = '0;
        due  = 1'b0;
      end else begin
        newdue = 0;
        for (int i = 0; i < NL; i++)
          if (in_req_i && !done[i] && out_gnt_i[lb[i]]) begin
            done[i]     = 1'b1;
            lane_exp[i] = word(lb[i], lr[i], cyc);
          end
        if (all) begin
          newdue   = 1;
          due_read = in_wen_i;
          for (int i = 0; i < NL; i++) due_data[i*32 +: 32] = lane_exp[i];
          done = '0;
        end
        due = (newdue != 0);
      end

      for (int b = 0; b < NB; b++) begin
        hit[b] = out_req_o[b] & out_gnt_i[b];
        pw[b]  = word(b, int'(out_add_o[b*32+2 +: 12]), cyc);
      end
      cyc++;
    end
  end

  // ---------------------------------------------------------------- bank responder
  initial begin : resp
    forever begin
      @(posedge clk_i);
      #1;
      for (int b = 0; b < NB; b++)
        out_r_data_i[b*32 +: 32] = hit[b] ? pw[b] : {16'hDEAD, 8'(b), 8'(cyc)};
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic idle();
    in_req_i = 1'b0; in_wen_i = 1'b0; in_add_i = '0; in_be_i = '0; in_data_i = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic wen, input logic [31:0] add, input logic [15:0] be,
                      input logic [127:0] data, input logic [7:0] smask, input int scyc,
                      output int n, output logic [7:0] req1, output logic [7:0] req2,
                      output logic [255:0] add1);
    logic got;
    in_req_i = 1'b1; in_wen_i = wen; in_add_i = add; in_be_i = be; in_data_i = data;
    out_gnt_i = (scyc > 0) ? ~smask : 8'hFF;
    n = 0; got = 1'b0; req1 = '0; req2 = '0; add1 = '0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      n++;
      if (n == 1) begin
        req1 = out_req_o;
        add1 = out_add_o;
      end
      if (n == 2) req2 = out_req_o;
      if (in_gnt_o) got = 1'b1;
      else begin
        @(posedge clk_i);
        #1;
        if (n >= scyc) out_gnt_i = 8'hFF;
      end
    end
    chk("gnt_timeout", got, 1'b1);
    @(posedge clk_i);
    #1;
    out_gnt_i = 8'hFF;
  endtask

  initial begin : stim
    int           n;
    logic [7:0]   r1, r2;
    logic [255:0] a1;
    rst_i = 1'b1; clear_i = 1'b0; idle(); out_gnt_i = 8'hFF; out_r_data_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_out_req", out_req_o, 8'h00);
    chk("rst_in_gnt", in_gnt_o, 1'b0);
    chk("rst_r_valid", in_r_valid_o, 1'b0);
`ifdef HCI_WIDE_IC_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt_o, 16'd0);
`endif
    step(1);
    rst_i = 1'b0;
    step(2);

    // aligned read at 0x40: banks 0-3, row 2
    send(1'b1, 32'h40, 16'hFFFF, '0, 8'h00, 0, n, r1, r2, a1);
    chk("al_cycles", n, 1);
    chk("al_req", r1, 8'h0F);
    chk("al_add_b0", a1[31:0], 32'h8);
    chk("al_add_b3", a1[127:96], 32'h8);
    idle();
    @(negedge clk_i);
    chk("al_r_valid", in_r_valid_o, 1'b1);
    chk("al_lane0", in_r_data_o[12 +: 20], 20'h00002);
    chk("al_lane1", in_r_data_o[44 +: 20], 20'h01002);
    chk("al_lane2", in_r_data_o[76 +: 20], 20'h02002);
    chk("al_lane3", in_r_data_o[108 +: 20], 20'h03002);
    step(2);

    // wrap read at 0x18: banks 6,7 row 0 then banks 0,1 row 1
    send(1'b1, 32'h18, 16'hFFFF, '0, 8'h00, 0, n, r1, r2, a1);
    chk("wr_req", r1, 8'hC3);
    chk("wr_add_b0", a1[31:0], 32'h4);
    chk("wr_add_b6", a1[223:192], 32'h0);
    idle();
    @(negedge clk_i);
    chk("wr_r_valid", in_r_valid_o, 1'b1);
    chk("wr_lane0", in_r_data_o[12 +: 20], 20'h06000);
    chk("wr_lane1", in_r_data_o[44 +: 20], 20'h07000);
    chk("wr_lane2", in_r_data_o[76 +: 20], 20'h00001);
    chk("wr_lane3", in_r_data_o[108 +: 20], 20'h01001);
    step(2);

    // partial grant: bank 2 held off for 3 cycles
    send(1'b1, 32'h0, 16'hFFFF, '0, 8'h04, 3, n, r1, r2, a1);
    chk("pg_cycles", n, 4);
    chk("pg_req_c1", r1, 8'h0F);
    chk("pg_req_c2", r2, 8'h04);
`ifdef HCI_WIDE_IC_STALL_CNT_EN
    chk("pg_stall_cnt", stall_cnt_o, 16'd3);
`endif
    idle();
    @(negedge clk_i);
    chk("pg_r_valid", in_r_valid_o, 1'b1);
    step(2);

    // back-to-back writes to 0x0 and 0x10
    send(1'b0, 32'h0, 16'hF0F1, 128'h44444444_33333333_22222222_11111111, 8'h00, 0, n, r1, r2, a1);
    chk("bb_cycles0", n, 1);
    send(1'b0, 32'h10, 16'h1234, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'h00, 0, n, r1, r2, a1);
    chk("bb_cycles1", n, 1);
    chk("bb_req1", r1, 8'hF0);
    idle();
    @(negedge clk_i);
    chk("bb_r_valid1", in_r_valid_o, 1'b1);
    step(2);

    // row wrap: row 0xFFF, offset 6
    send(1'b1, 32'h1FFF8, 16'hFFFF, '0, 8'h00, 0, n, r1, r2, a1);
    chk("rw_req", r1, 8'hC3);
    chk("rw_add_b6", a1[223:192], 32'h3FFC);
    chk("rw_add_b7", a1[255:224], 32'h3FFC);
    chk("rw_add_b0", a1[31:0], 32'h0);
    chk("rw_add_b1", a1[63:32], 32'h0);
    idle();
    @(negedge clk_i);
    chk("rw_lane0", in_r_data_o[12 +: 20], 20'h06FFF);
    chk("rw_lane2", in_r_data_o[76 +: 20], 20'h00000);
    step(2);

    // reset pulsed while bank 2 stalls
    in_req_i = 1'b1; in_wen_i = 1'b1; in_add_i = 32'h0; in_be_i = 16'hFFFF; in_data_i = '0;
    out_gnt_i = 8'hFB;
    step(2);
    rst_i = 1'b1;
    idle();
    out_gnt_i = 8'hFF;
    @(negedge clk_i);
    chk("mr_out_req", out_req_o, 8'h00);
    chk("mr_out_add", out_add_o, 256'h0);
    chk("mr_out_be", out_be_o, 32'h0);
    chk("mr_in_gnt", in_gnt_o, 1'b0);
    chk("mr_r_valid", in_r_valid_o, 1'b0);
`ifdef HCI_WIDE_IC_STALL_CNT_EN
    chk("mr_stall_cnt", stall_cnt_o, 16'd0);
`endif
    step(1);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("mr_no_resp", in_r_valid_o, 1'b0);
    end
    step(1);
    send(1'b1, 32'h40, 16'hFFFF, '0, 8'h00, 0, n, r1, r2, a1);
    chk("mr_next_cycles", n, 1);
    idle();
    @(negedge clk_i);
    chk("mr_next_r_valid", in_r_valid_o, 1'b1);
    step(2);

    // synchronous clear while bank 2 stalls
    in_req_i = 1'b1; in_wen_i = 1'b1; in_add_i = 32'h0; in_be_i = 16'hFFFF; in_data_i = '0;
    out_gnt_i = 8'hFB;
    step(2);
    clear_i = 1'b1;
    idle();
    out_gnt_i = 8'hFF;
    step(1);
    clear_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("cl_no_resp", in_r_valid_o, 1'b0);
      chk("cl_no_req", out_req_o, 8'h00);
    end
    step(1);
    send(1'b1, 32'h18, 16'hFFFF, '0, 8'h00, 0, n, r1, r2, a1);
    chk("cl_next_req", r1, 8'hC3);
    idle();
    @(negedge clk_i);
    chk("cl_next_r_valid", in_r_valid_o, 1'b1);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
